mac_arbiter: RTL
================

Name: mac_arbiter

Overview:
- Shares a single `binary` multiply-accumulate unit (out = a*b + c, SIZE-bit operands, 2*SIZE-bit result) between NREQ independent requesters.
- Arbitrates round-robin and issues the winner's operands to the MAC using its valid/ready handshake.
- Returns the result tagged with the requester index on a back-pressured response port.
- Sits between the compute clients and the MAC instance. The MAC may be combinational (ready tied high) or multi-cycle.

Parameters:
- SIZE, 3, operand width of a, b, c; result width is 2*SIZE.
- NREQ, 4, number of requesters (>=2); ID_W = $clog2(NREQ).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  NREQ*SIZE  packed operand a, requester i at [i*SIZE +: SIZE].
- req_b  input  NREQ*SIZE  packed operand b, same packing.
- req_c  input  NREQ*SIZE  packed operand c, same packing.
- req_ready  output  NREQ  one-hot accept; transfer when req_valid[i] & req_ready[i].
- mac_valid  output  1  operands on mac_a/b/c valid for the MAC.
- mac_a  output  SIZE  MAC operand a (registered).
- mac_b  output  SIZE  MAC operand b (registered).
- mac_c  output  SIZE  MAC operand c (registered).
- mac_ready  input  1  MAC result on mac_out valid this cycle.
- mac_out  input  2*SIZE  MAC result.
- rsp_valid  output  1  response valid.
- rsp_id  output  ID_W  index of requester owning rsp_data.
- rsp_data  output  2*SIZE  captured MAC result.
- rsp_ready  input  1  consumer accepts response.

Behaviour:
- Reset (async, reset_n=0):
  - State is IDLE and last_grant = NREQ-1, so requester 0 wins first.
  - mac_valid=0; mac_a/b/c=0; rsp_valid=0; rsp_id=0; rsp_data=0.
  - req_ready=0 while reset_n=0.
  - A reset mid-transaction discards the in-flight operation; no response is ever produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP. Only one transaction is in flight at a time.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning (last_grant+1) mod NREQ upward with wrap.
  - req_ready is combinational: one-hot for the winner in IDLE only, all-zero otherwise, and all-zero if no req_valid.
  - On transfer: register the winner's a/b/c into mac_a/b/c, set sel_id=winner and last_grant=winner, go to ISSUE.
- ISSUE:
  - mac_valid=1.
  - If mac_ready=1: capture rsp_data=mac_out and rsp_id=sel_id, go to RESP.
  - Else go to WAIT.
- WAIT:
  - mac_valid stays 1; mac_a/b/c are held stable.
  - On mac_ready=1: capture as in ISSUE, go to RESP.
  - No timeout.
- RESP:
  - mac_valid=0; rsp_valid=1; rsp_id and rsp_data are held stable until rsp_ready.
  - On rsp_ready=1, go to IDLE; rsp_valid drops in the next cycle.
- Outside ISSUE/WAIT, mac_valid=0. mac_a/b/c retain their last values (not cleared).
- Latency with combinational MAC (mac_ready tied 1):
  - Accept at cycle T; mac_valid at T+1; rsp_valid at T+2.
  - With rsp_ready=1, the next accept can happen at T+3.
  - Peak throughput is 1 result per 3 cycles.
- Width: rsp_data = mac_out unmodified; no saturation or truncation. a*b+c always fits in 2*SIZE bits.
- Requester rules:
  - A requester must hold req_valid and its operands until accepted.
  - Dropping req_valid before acceptance is legal and has no side effect.
  - req_valid changes during non-IDLE states are ignored.
- Fairness: a continuously requesting set of N requesters is each served exactly once per N grants. No requester waits more than NREQ-1 grants.
- rsp_ready held 0 stalls the arbiter in RESP indefinitely; no new requests are accepted.

Test Plan:
- Reset then req_valid=4'b0001 with a=3, b=5, c=2, mac_ready tied 1, rsp_ready=1:
  - req_ready=4'b0001 at accept cycle; mac_a/b/c=3/5/2 with mac_valid=1 one cycle later.
  - rsp_valid=1, rsp_id=0, rsp_data=17 two cycles after accept.
- req_valid=4'b1111 held, all operands a=7, b=7, c=7, mac_ready=1, rsp_ready=1:
  - Grants in order 0,1,2,3,0,... with a grant every 3 cycles.
  - Every rsp_data=56 (max value, no overflow).
- Multi-cycle MAC: a bench model raises mac_ready 4 cycles after mac_valid, requester 2 with a=6, b=4, c=1:
  - mac_valid stays 1 and mac_a/b/c stay stable through WAIT.
  - rsp_id=2, rsp_data=25 in the cycle after mac_ready.
- Back-pressure: hold rsp_ready=0 for 5 cycles with req_valid=4'b0110 pending:
  - rsp_valid/rsp_id/rsp_data stay stable; req_ready stays 0.
  - After rsp_ready=1, the next grant goes round-robin (1 served -> 2 next).
- Assert reset_n=0 asynchronously while in WAIT:
  - mac_valid and rsp_valid go 0 immediately; no response for the aborted request.
  - The first grant after release goes to requester 0.
- Requester 3 raises then drops req_valid before grant while requester 1 holds:
  - Only requester 1 is accepted; no transaction for 3.

Source files
------------

// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one valid/ready multiply-accumulate unit between NREQ requesters.
// One transaction in flight; the result returns tagged with the owner's index.
module mac_arbiter #(
  parameter int unsigned SIZE = 3,
  parameter int unsigned NREQ = 4,
  localparam int unsigned ID_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*SIZE-1:0] req_a,
  input  logic [NREQ*SIZE-1:0] req_b,
  input  logic [NREQ*SIZE-1:0] req_c,
  output logic [NREQ-1:0]      req_ready,
  output logic                 mac_valid,
  output logic [SIZE-1:0]      mac_a,
  output logic [SIZE-1:0]      mac_b,
  output logic [SIZE-1:0]      mac_c,
  input  logic                 mac_ready,
  input  logic [2*SIZE-1:0]    mac_out,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [2*SIZE-1:0]    rsp_data,
  input  logic                 rsp_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] sel_id;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] cand;
  logic            found;
  logic            accept;
  logic            capture;
  logic            release_rsp;

  // Round-robin search starting just after the previous grant.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = ID_W'((32'(last_grant) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Accept is offered only in IDLE and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && reset_n && found) req_ready[winner] = 1'b1;
  end

  assign accept = (state == IDLE) && found;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state)
      IDLE:  if (accept) state_next = ISSUE;
      ISSUE: begin
        if (mac_ready) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mac_ready) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          release_rsp = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand issue and result capture; operands keep their last values between transactions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mac_valid  <= 1'b0;
      mac_a      <= '0;
      mac_b      <= '0;
      mac_c      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      sel_id     <= '0;
      last_grant <= ID_W'(NREQ - 1);
    end else begin
      if (accept) begin
        mac_valid  <= 1'b1;
        mac_a      <= req_a[32'(winner)*SIZE +: SIZE];
        mac_b      <= req_b[32'(winner)*SIZE +: SIZE];
        mac_c      <= req_c[32'(winner)*SIZE +: SIZE];
        sel_id     <= winner;
        last_grant <= winner;
      end
      if (capture) begin
        mac_valid <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_id    <= sel_id;
        rsp_data  <= mac_out;
      end
      if (release_rsp) rsp_valid <= 1'b0;
    end
  end

endmodule
